// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice.
//   pstate_t     - stall scheduler FSM state (RUN / DWAIT / HALTED)
//   stage_ctrl_t - per-stage register enables and bubble-load (flush) controls
//   ROW_*        - id of the priority row that decided the current cycle
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } pstate_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  localparam logic [2:0] ROW_HALT    = 3'd1;
  localparam logic [2:0] ROW_DSTALL  = 3'd2;
  localparam logic [2:0] ROW_BR_OK   = 3'd3;
  localparam logic [2:0] ROW_BR_WAIT = 3'd4;
  localparam logic [2:0] ROW_LU      = 3'd5;
  localparam logic [2:0] ROW_IMISS   = 3'd6;
  localparam logic [2:0] ROW_RUN     = 3'd7;

endpackage

// File: rtl/pipeline_stall_ctrl_stall_prio_dec.sv
// stall_prio_dec: purely combinational priority decoder for the stall/flush
// scheduler. Evaluates the decision rows top-down; the first match wins.
// Ports:
//   state      in  current scheduler state
//   halt_req   in  halt instruction in MEM/WB
//   dstall     in  dcache access in MEM not yet complete
//   fetch_ok   in  an instruction is available (icache hit or skid valid)
//   branch     in  taken branch/jump resolved in EX
//   lu_hazard  in  load-use hazard
//   ctrl       out stage enables / flushes
//   row        out id of the deciding row (ROW_* in cpu_types_pkg)
module stall_prio_dec
  import cpu_types_pkg::*;
(
  input  pstate_t     state,
  input  logic        halt_req,
  input  logic        dstall,
  input  logic        fetch_ok,
  input  logic        branch,
  input  logic        lu_hazard,
  output stage_ctrl_t ctrl,
  output logic [2:0]  row
);

  always_comb begin
    ctrl = '0;
    row  = ROW_RUN;
    if (state == HALTED || halt_req) begin
      row = ROW_HALT;
    end else if (dstall) begin
      // Freeze everything up to MEM; WB keeps draining with bubbles.
      row              = ROW_DSTALL;
      ctrl.memwb_en    = 1'b1;
      ctrl.memwb_flush = 1'b1;
    end else if (branch && fetch_ok) begin
      // Redirect: squash the two wrong-path instructions behind the branch.
      row             = ROW_BR_OK;
      ctrl.pc_en      = 1'b1;
      ctrl.ifid_en    = 1'b1;
      ctrl.idex_en    = 1'b1;
      ctrl.exmem_en   = 1'b1;
      ctrl.memwb_en   = 1'b1;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (branch) begin
      // Branch must wait for the in-flight fetch; keep it in EX and let
      // a bubble advance into MEM so it is not executed twice.
      row              = ROW_BR_WAIT;
      ctrl.exmem_en    = 1'b1;
      ctrl.exmem_flush = 1'b1;
      ctrl.memwb_en    = 1'b1;
    end else if (lu_hazard) begin
      row             = ROW_LU;
      ctrl.idex_en    = 1'b1;
      ctrl.idex_flush = 1'b1;
      ctrl.exmem_en   = 1'b1;
      ctrl.memwb_en   = 1'b1;
    end else if (!fetch_ok) begin
      row             = ROW_IMISS;
      ctrl.ifid_en    = 1'b1;
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_en    = 1'b1;
      ctrl.exmem_en   = 1'b1;
      ctrl.memwb_en   = 1'b1;
    end else begin
      ctrl.pc_en    = 1'b1;
      ctrl.ifid_en  = 1'b1;
      ctrl.idex_en  = 1'b1;
      ctrl.exmem_en = 1'b1;
      ctrl.memwb_en = 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central stall/flush scheduler for the 5-stage pipeline.
// Priority: halt > dcache wait > branch redirect > load-use > icache miss.
// A skid flag remembers an icache hit that arrived while IF/ID was frozen.
// Optional build macro STALL_CNT_EN adds saturating per-cause cycle counters
// (cnt_dstall, cnt_istall, cnt_lu, cnt_flush) and the CNT_W parameter.
// Ports:
//   CLK, RST                     clock, synchronous active-high reset
//   ihit, dhit                   icache / dcache completion
//   exmem_dren, exmem_dwen       load / store in EX/MEM
//   lu_hazard, ex_branch_taken   hazard unit and EX redirect
//   memwb_halt                   halt instruction in MEM/WB
//   *_en, *_flush                stage register enables and bubble loads
//   ifetch_hold, ifetch_use_skid skid register capture / select
//   hazard_detected, halted, dwait_err, state_o  status/debug
module pipeline_stall_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DWAIT_MAX = 255
`ifdef STALL_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ihit,
  input  logic       dhit,
  input  logic       exmem_dren,
  input  logic       exmem_dwen,
  input  logic       lu_hazard,
  input  logic       ex_branch_taken,
  input  logic       memwb_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       ifetch_hold,
  output logic       ifetch_use_skid,
  output logic       hazard_detected,
  output logic       halted,
  output logic       dwait_err,
  output logic [1:0] state_o
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_dstall,
  output logic [CNT_W-1:0] cnt_istall,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  localparam int DCNT_W = (DWAIT_MAX < 1) ? 1 : $clog2(DWAIT_MAX + 1);
  localparam logic [DCNT_W-1:0] DWAIT_LIM = DCNT_W'(DWAIT_MAX);

  pstate_t           state_reg, state_next;
  logic              skid_v_reg, skid_v_next;
  logic [DCNT_W-1:0] dwait_cnt_reg, dwait_cnt_next;
  logic              dwait_err_reg, dwait_err_next;

  logic        dstall;
  logic        fetch_ok;
  stage_ctrl_t dec_ctrl;
  stage_ctrl_t ctrl;
  logic [2:0]  row;

  assign dstall   = (exmem_dren | exmem_dwen) & ~dhit;
  assign fetch_ok = ihit | skid_v_reg;

  stall_prio_dec u_dec (
    .state     (state_reg),
    .halt_req  (memwb_halt),
    .dstall    (dstall),
    .fetch_ok  (fetch_ok),
    .branch    (ex_branch_taken),
    .lu_hazard (lu_hazard),
    .ctrl      (dec_ctrl),
    .row       (row)
  );

  // A reset cycle forces every stage idle, overriding any stall in progress.
  assign ctrl = RST ? '0 : dec_ctrl;

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign memwb_en    = ctrl.memwb_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_flush = ctrl.memwb_flush;

  assign halted = ~RST & (row == ROW_HALT);

  assign hazard_detected = ~RST & (row != ROW_HALT) &
      (~&{ctrl.pc_en, ctrl.ifid_en, ctrl.idex_en, ctrl.exmem_en, ctrl.memwb_en} |
        |{ctrl.ifid_flush, ctrl.idex_flush, ctrl.exmem_flush, ctrl.memwb_flush});

  // Capture a returning instruction that IF/ID cannot accept this cycle.
  assign ifetch_hold     = ~RST & ihit & ~skid_v_reg & ~ctrl.ifid_en;
  assign ifetch_use_skid = skid_v_reg;

  assign dwait_err = dwait_err_reg;
  assign state_o   = state_reg;

  always_comb begin
    state_next     = RUN;
    dwait_cnt_next = '0;
    dwait_err_next = dwait_err_reg;
    skid_v_next    = skid_v_reg;

    if (row == ROW_HALT) begin
      state_next = HALTED;
    end else if (row == ROW_DSTALL) begin
      state_next = DWAIT;
      if (dwait_cnt_reg == DWAIT_LIM) begin
        dwait_cnt_next = DWAIT_LIM;
        dwait_err_next = 1'b1;
      end else begin
        dwait_cnt_next = dwait_cnt_reg + 1'b1;
      end
    end

    // Skid is consumed by a real IF/ID load and discarded on a redirect.
    if (row == ROW_BR_OK) begin
      skid_v_next = 1'b0;
    end else if (ctrl.ifid_en && !ctrl.ifid_flush) begin
      skid_v_next = 1'b0;
    end else if (ifetch_hold) begin
      skid_v_next = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= RUN;
      skid_v_reg    <= 1'b0;
      dwait_cnt_reg <= '0;
      dwait_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      skid_v_reg    <= skid_v_next;
      dwait_cnt_reg <= dwait_cnt_next;
      dwait_err_reg <= dwait_err_next;
    end
  end

`ifdef STALL_CNT_EN
  // Counter order: 0 dstall, 1 istall (branch wait or icache miss), 2 lu, 3 flush.
  logic [3:0] cnt_hit;
  assign cnt_hit = {row == ROW_BR_OK,
                    row == ROW_LU,
                    (row == ROW_BR_WAIT) || (row == ROW_IMISS),
                    row == ROW_DSTALL};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge CLK) begin
        if (RST) begin
          cnt_reg <= '0;
        end else if (cnt_hit[gi] && !(&cnt_reg)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_dstall = g_cnt[0].cnt_reg;
  assign cnt_istall = g_cnt[1].cnt_reg;
  assign cnt_lu     = g_cnt[2].cnt_reg;
  assign cnt_flush  = g_cnt[3].cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (DWAIT_MAX=4).
// Each cycle: inputs applied 1 time unit after the rising edge, the expected
// output set is pushed to a scoreboard queue, then popped and compared
// mid-cycle against the combinational outputs.
// Input vector order:    {RST, ihit, dhit, dren, dwen, lu, br, halt}
// Expected en order:     {pc, ifid, idex, exmem, memwb}
// Expected flush order:  {ifid, idex, exmem, memwb}
// Expected flag order:   {ifetch_hold, ifetch_use_skid, hazard_detected, halted, dwait_err}
module tb_pipeline_stall_ctrl;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, exmem_dren, exmem_dwen, lu_hazard, ex_branch_taken, memwb_halt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic ifetch_hold, ifetch_use_skid, hazard_detected, halted, dwait_err;
  logic [1:0] state_o;

  always #5 CLK = ~CLK;

  pipeline_stall_ctrl #(.DWAIT_MAX(4)) dut (
    .CLK             (CLK),
    .RST             (RST),
    .ihit            (ihit),
    .dhit            (dhit),
    .exmem_dren      (exmem_dren),
    .exmem_dwen      (exmem_dwen),
    .lu_hazard       (lu_hazard),
    .ex_branch_taken (ex_branch_taken),
    .memwb_halt      (memwb_halt),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .memwb_flush     (memwb_flush),
    .ifetch_hold     (ifetch_hold),
    .ifetch_use_skid (ifetch_use_skid),
    .hazard_detected (hazard_detected),
    .halted          (halted),
    .dwait_err       (dwait_err),
    .state_o         (state_o)
  );

  typedef struct {
    string      name;
    logic [4:0] en;
    logic [3:0] fl;
    logic [4:0] fg;
    logic [1:0] st;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string name, input logic [7:0] in, input logic [4:0] en,
                     input logic [3:0] fl, input logic [4:0] fg, input logic [1:0] st);
    exp_t e;
    @(posedge CLK);
    #1;
    {RST, ihit, dhit, exmem_dren, exmem_dwen, lu_hazard, ex_branch_taken, memwb_halt} = in;
    e.name = name;
    e.en   = en;
    e.fl   = fl;
    e.fg   = fg;
    e.st   = st;
    sb_q.push_back(e);
    #3;
    e = sb_q.pop_front();
    check({e.name, ".en"}, {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, e.en);
    check({e.name, ".flush"}, {ifid_flush, idex_flush, exmem_flush, memwb_flush}, e.fl);
    check({e.name, ".flags"}, {ifetch_hold, ifetch_use_skid, hazard_detected, halted, dwait_err}, e.fg);
    check({e.name, ".state"}, state_o, e.st);
    txn++;
    $display("txn %0d %s in=%b en=%b fl=%b flags=%b st=%0d", txn, e.name, in,
             {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
             {ifid_flush, idex_flush, exmem_flush, memwb_flush},
             {ifetch_hold, ifetch_use_skid, hazard_detected, halted, dwait_err}, state_o);
  endtask

  initial begin
    {RST, ihit, dhit, exmem_dren, exmem_dwen, lu_hazard, ex_branch_taken, memwb_halt} = 8'b1100_0000;

    // Reset held for two cycles; the second is checked.
    cyc("reset",     8'b1100_0000, 5'b00000, 4'b0000, 5'b00000, 2'd0);
    cyc("idle0",     8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);
    cyc("idle1",     8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);
    // Icache miss: PC held, IF/ID gets a bubble.
    cyc("imiss",     8'b0000_0000, 5'b01111, 4'b1000, 5'b00100, 2'd0);

    // Dcache wait 3 cycles with an ihit on the second; release with skid.
    cyc("dw1",       8'b0001_0000, 5'b00001, 4'b0001, 5'b00100, 2'd0);
    cyc("dw2_ihit",  8'b0101_0000, 5'b00001, 4'b0001, 5'b10100, 2'd1);
    cyc("dw3",       8'b0001_0000, 5'b00001, 4'b0001, 5'b01100, 2'd1);
    cyc("dw_rel",    8'b0011_0000, 5'b11111, 4'b0000, 5'b01000, 2'd1);
    cyc("dw_after",  8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    // Branch waiting on fetch, then redirect.
    cyc("brw1",      8'b0000_0010, 5'b00011, 4'b0010, 5'b00100, 2'd0);
    cyc("brw2",      8'b0000_0010, 5'b00011, 4'b0010, 5'b00100, 2'd0);
    cyc("br_ok",     8'b0100_0010, 5'b11111, 4'b1100, 5'b00100, 2'd0);
    cyc("br_after",  8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    // Load-use: IF/ID frozen, so the arriving instruction goes to the skid.
    cyc("lu",        8'b0100_0100, 5'b00111, 4'b0100, 5'b10100, 2'd0);
    cyc("lu_next",   8'b0100_0000, 5'b11111, 4'b0000, 5'b01000, 2'd0);
    cyc("lu_idle",   8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    // Priority: store wait beats branch and load-use; then branch beats load-use.
    cyc("prio_ds",   8'b0000_1110, 5'b00001, 4'b0001, 5'b00100, 2'd0);
    cyc("prio_br",   8'b0110_1110, 5'b11111, 4'b1100, 5'b00100, 2'd1);
    cyc("prio_idle", 8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    // Reset in the middle of a dcache stall.
    cyc("rs_dw",     8'b0001_0000, 5'b00001, 4'b0001, 5'b00100, 2'd0);
    cyc("rs_rst",    8'b1101_0000, 5'b00000, 4'b0000, 5'b00000, 2'd1);
    cyc("rs_idle",   8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    // Long dcache wait: dwait_err visible after the 5th stall cycle (DWAIT_MAX=4).
    for (int i = 0; i < 6; i++) begin
      cyc($sformatf("dwl%0d", i), 8'b0001_0000, 5'b00001, 4'b0001,
          (i == 5) ? 5'b00101 : 5'b00100, (i == 0) ? 2'd0 : 2'd1);
    end
    cyc("dwl_rel",   8'b0111_0000, 5'b11111, 4'b0000, 5'b00001, 2'd1);
    cyc("dwl_idle",  8'b0100_0000, 5'b11111, 4'b0000, 5'b00001, 2'd0);

    // Halt, then random inputs must not disturb it.
    cyc("halt",      8'b0000_0001, 5'b00000, 4'b0000, 5'b00011, 2'd0);
    for (int i = 0; i < 10; i++) begin
      logic [5:0] r;
      r = 6'($urandom);
      cyc($sformatf("halted%0d", i), {2'b00, r}, 5'b00000, 4'b0000, 5'b00011, 2'd2);
    end
    cyc("halt_rst",  8'b1100_0000, 5'b00000, 4'b0000, 5'b00001, 2'd2);
    cyc("post_rst",  8'b0100_0000, 5'b11111, 4'b0000, 5'b00000, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
